muldiv_unit: RTL and testbench

- Parametrised RV M-extension multiply/divide unit; successor to the fixed 32-bit mul/div top.
- Sits beside the ALU in the execute stage.
- Accepts one operation per valid/ready handshake and returns one XLEN result on a valid/ready output.
- Adds width generalisation, a configurable multiplier latency, a configurable divider radix, a flush input, and 1-cycle fast paths.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_div_core.sv | 76 +++++++
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings for the M-extension unit.
// Also provides the per-op operand signedness helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // {a_signed, b_signed}; MUL low half is sign-agnostic
  function automatic logic [1:0] op_sign(
    input logic [2:0] op
  );
    logic [1:0] s;
    s = 2'b00;
    unique case (1'b1)
      (op == OP_MULH),
      (op == OP_DIV),
      (op == OP_REM):    s = 2'b11;
      (op == OP_MULHSU): s = 2'b10;
      default:           s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: iterative restoring divider on magnitudes.
// Retires DIV_BITS quotient bits per cycle; done pulses once.
module muldiv_div_core #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  import muldiv_pkg::*;

  localparam int ITERS = XLEN / DIV_BITS;
  localparam int CW    = $clog2(ITERS);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] q_n;
  logic [XLEN-1:0] r_n;
  logic [XLEN:0]   t;

  // DIV_BITS restoring shift/subtract steps per cycle
  always_comb begin
    q_n = quotient;
    r_n = remainder;
    t   = '0;
    for (int j = 0; j < DIV_BITS; j++) begin
      t   = {r_n, q_n[XLEN-1]};
      q_n = {q_n[XLEN-2:0], 1'b0};
      if (t >= {1'b0, dvs_q}) begin
        t      = t - {1'b0, dvs_q};
        q_n[0] = 1'b1;
      end
      r_n = t[XLEN-1:0];
    end
  end

  // load on start, iterate while busy, pulse done on last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy_q <= 1'b0;
      end else if (start) begin
        busy_q    <= 1'b1;
        cnt_q     <= '0;
        dvs_q     <= divisor;
        quotient  <= dividend;
        remainder <= '0;
      end else if (busy_q) begin
        quotient  <= q_n;
        remainder <= r_n;
        cnt_q     <= cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension mul/div beside the execute-stage ALU.
// Optional MULDIV_REM_FUSE_EN adds a 1-entry quotient/remainder cache.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  import muldiv_pkg::*;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [2:0]      cnt_q;

  logic            accept, fast, b_zero, ovf, hit;
  logic [1:0]      sgn_in, sgn_q;
  logic            a_neg_in, b_neg_in, a_neg_q, b_neg_q;
  logic [XLEN-1:0] mag_a_in, mag_b_in, mag_a_q, mag_b_q;
  logic [XLEN-1:0] fast_res, hit_res, mul_res, div_res;
  logic [XLEN-1:0] q_mag, r_mag, q_fix, r_fix;
  logic [2*XLEN-1:0] prod_c, mul_tap, mul_fix;
  logic            div_done, last_mul;

  assign accept   = (state_q == ST_IDLE) && in_valid && !flush;
  assign sgn_in   = op_sign(in_op);
  assign a_neg_in = sgn_in[1] & in_a[XLEN-1];
  assign b_neg_in = sgn_in[0] & in_b[XLEN-1];
  assign mag_a_in = a_neg_in ? -in_a : in_a;
  assign mag_b_in = b_neg_in ? -in_b : in_b;
  assign b_zero   = (in_b == '0);
  assign ovf      = sgn_in[1] && (in_a == MOST_NEG) && (in_b == '1);
  assign fast     = in_op[2] && (b_zero || ovf || hit);

  // result for ops resolved in the capture cycle
  always_comb begin
    fast_res = hit_res;
    unique case (1'b1)
      b_zero:  fast_res = in_op[1] ? in_a : '1;
      ovf:     fast_res = in_op[1] ? '0 : in_a;
      default: fast_res = hit_res;
    endcase
  end

  assign sgn_q   = op_sign(op_q);
  assign a_neg_q = sgn_q[1] & a_q[XLEN-1];
  assign b_neg_q = sgn_q[0] & b_q[XLEN-1];
  assign mag_a_q = a_neg_q ? -a_q : a_q;
  assign mag_b_q = b_neg_q ? -b_q : b_q;
  assign prod_c  = {{XLEN{1'b0}}, mag_a_q} *
                   {{XLEN{1'b0}}, mag_b_q};

  generate
    if (MUL_STAGES == 1) begin : g_nopipe
      assign mul_tap = prod_c;
    end else begin : g_pipe
      logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
      // product delay line; tap lines up with the last MUL cycle
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < MUL_STAGES - 1; i++)
            pipe[i] <= '0;
        end else begin
          pipe[0] <= prod_c;
          for (int i = 1; i < MUL_STAGES - 1; i++)
            pipe[i] <= pipe[i-1];
        end
      end
      assign mul_tap = pipe[MUL_STAGES-2];
    end
  endgenerate

  assign mul_fix  = (a_neg_q ^ b_neg_q) ? -mul_tap : mul_tap;
  assign mul_res  = (op_q == OP_MUL) ? mul_fix[XLEN-1:0]
                                     : mul_fix[2*XLEN-1:XLEN];
  assign last_mul = (cnt_q == 3'(MUL_STAGES - 1));

  muldiv_div_core #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && in_op[2] && !fast),
    .abort     (flush),
    .dividend  (mag_a_in),
    .divisor   (mag_b_in),
    .done      (div_done),
    .quotient  (q_mag),
    .remainder (r_mag)
  );

  assign q_fix   = (a_neg_q ^ b_neg_q) ? -q_mag : q_mag;
  assign r_fix   = a_neg_q ? -r_mag : r_mag;
  assign div_res = op_q[1] ? r_fix : q_fix;

`ifdef MULDIV_REM_FUSE_EN
  logic            c_vld, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;

  assign hit = in_op[2] && c_vld && (in_a == c_a) &&
               (in_b == c_b) && (sgn_in[1] == c_sgn);
  assign hit_res = in_op[1] ? c_r : c_q;

  // remember the last iterative divide; drop on flush or MUL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_vld <= 1'b0;
      c_sgn <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
    end else if (flush) begin
      c_vld <= 1'b0;
    end else if (accept && !in_op[2]) begin
      c_vld <= 1'b0;
    end else if (state_q == ST_DIV && div_done) begin
      c_vld <= 1'b1;
      c_sgn <= sgn_q[1];
      c_a   <= a_q;
      c_b   <= b_q;
      c_q   <= q_fix;
      c_r   <= r_fix;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (in_valid)
            state_d = fast     ? ST_DONE :
                      in_op[2] ? ST_DIV  : ST_MUL;
        ST_MUL:  if (last_mul)  state_d = ST_DONE;
        ST_DIV:  if (div_done)  state_d = ST_DONE;
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // handshake and status outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !flush;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // operand capture, MUL step count and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= in_op;
        a_q   <= in_a;
        b_q   <= in_b;
        cnt_q <= '0;
        if (fast) res_q <= fast_res;
      end
      if (state_q == ST_MUL) begin
        cnt_q <= cnt_q + 3'd1;
        if (last_mul) res_q <= mul_res;
      end
      if (state_q == ST_DIV && div_done)
        res_q <= div_res;
    end
  end

  assign out_result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit.
// 32-bit default instance plus a 64-bit radix-4 instance.
module tb_muldiv_unit;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v32, r32, fl32, ov32, ordy32, busy32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        v64, r64, fl64, ov64, ordy64, busy64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, res64;

  muldiv_unit u32 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (v32),
    .in_ready   (r32),
    .in_op      (op32),
    .in_a       (a32),
    .in_b       (b32),
    .flush      (fl32),
    .out_valid  (ov32),
    .out_ready  (ordy32),
    .out_result (res32),
    .busy       (busy32)
  );

  muldiv_unit #(.XLEN(64), .MUL_STAGES(2), .DIV_BITS(2)) u64 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (v64),
    .in_ready   (r64),
    .in_op      (op64),
    .in_a       (a64),
    .in_b       (b64),
    .flush      (fl64),
    .out_valid  (ov64),
    .out_ready  (ordy64),
    .out_result (res64),
    .busy       (busy64)
  );

  int vectors = 0;
  int miscompares = 0;

  bit          c_ok = 1'b0;
  bit          c_s;
  logic [31:0] c_a, c_b;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == MIN32) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (!op[2]) return 3;
    if (b == 0) return 1;
    if (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_REM_FUSE_EN
    if (c_ok && c_a == a && c_b == b && c_s == !op[0]) return 1;
`endif
    return 34;
  endfunction

  task automatic model_upd(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input int lat);
    if (!op[2]) begin
      c_ok = 1'b0;
    end else if (lat == 34) begin
      c_ok = 1'b1;
      c_a  = a;
      c_b  = b;
      c_s  = !op[0];
    end
  endtask

  task automatic do_op(input bit w64, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_r, input int exp_lat,
                       input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    if (w64) begin
      v64 = 1'b1; op64 = op; a64 = a; b64 = b;
    end else begin
      v32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
    chk({tag, ".in_ready"}, w64 ? r64 : r32, 1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v64 = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (w64 ? ov64 : ov32) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, w64 ? res64 : {32'b0, res32}, exp_r);
    @(posedge clk);
    #1;
    chk({tag, ".idle"}, w64 ? r64 : r32, 1);
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    int lat;
    lat = ref_lat(op, a, b);
    do_op(1'b0, op, {32'b0, a}, {32'b0, b},
          {32'b0, ref_res(op, a, b)}, lat, tag);
    model_upd(op, a, b, lat);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, hold;
    bit          saw;
    int          k;

    reset = 1'b0;
    v32 = 0; op32 = 0; a32 = 0; b32 = 0; fl32 = 0; ordy32 = 1;
    v64 = 0; op64 = 0; a64 = 0; b64 = 0; fl64 = 0; ordy64 = 1;
    #12;
    chk("rst.in_ready", r32, 1);
    chk("rst.out_valid", ov32, 0);
    chk("rst.out_result", res32, 0);
    chk("rst.busy", busy32, 0);
    chk("rst.out_result64", res64, 0);
    @(negedge clk);
    reset = 1'b1;

    run32(3'd1, 32'hFFFF_FFFF, 32'h2, "mulh");
    run32(3'd0, 32'hFFFF_FFFF, 32'h2, "mul");
    run32(3'd4, 32'hFFFF_FFF9, 32'h2, "div");
    run32(3'd6, 32'hFFFF_FFF9, 32'h2, "rem");
    run32(3'd5, 32'h1234, 32'h0, "divu0");
    run32(3'd7, 32'h1234, 32'h0, "remu0");
    run32(3'd4, MIN32, 32'hFFFF_FFFF, "div_ovf");
    run32(3'd6, MIN32, 32'hFFFF_FFFF, "rem_ovf");
    run32(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu");

    // backpressure: hold the result for 10 cycles
    ordy32 = 1'b0;
    @(negedge clk);
    v32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    k = 0;
    while (!ov32 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("bp.valid", ov32, 1);
    hold = res32;
    chk("bp.res", hold, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_valid", ov32, 1);
      chk("bp.hold_res", res32, hold);
      chk("bp.hold_in_ready", r32, 0);
    end
    @(negedge clk);
    ordy32 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_in_ready", r32, 1);
    chk("bp.release_valid", ov32, 0);
    model_upd(3'd5, 32'd100, 32'd7, ref_lat(3'd5, 32'd100, 32'd7));

    // flush in the 5th DIV cycle
    @(negedge clk);
    v32 = 1'b1; op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    saw = ov32;
    repeat (4) begin
      @(posedge clk);
      #1;
      saw |= ov32;
    end
    @(negedge clk);
    fl32 = 1'b1;
    @(posedge clk);
    #1;
    chk("flush.busy", busy32, 0);
    chk("flush.valid", ov32, 0);
    @(negedge clk);
    fl32 = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      saw |= ov32;
    end
    chk("flush.never_valid", saw, 0);
    c_ok = 1'b0;
    run32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");

    // request alongside flush must be ignored
    @(negedge clk);
    fl32 = 1'b1; v32 = 1'b1; op32 = 3'd0; a32 = 3; b32 = 5;
    #1;
    chk("flush_req.in_ready", r32, 0);
    @(posedge clk);
    #1;
    chk("flush_req.busy", busy32, 0);
    @(negedge clk);
    fl32 = 1'b0;
    v32  = 1'b0;
    c_ok = 1'b0;

    // random ops against the reference model
    a = 0;
    b = 1;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        k = $urandom_range(0, 9);
        a = (k == 0) ? MIN32 :
            (k == 1) ? 32'hFFFF_FFFF :
            (k == 2) ? 32'($urandom_range(0, 20)) : $urandom;
        k = $urandom_range(0, 9);
        b = (k == 0) ? 32'h0 :
            (k == 1) ? 32'hFFFF_FFFF :
            (k == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      end
      run32(op, a, b, $sformatf("rnd%0d.op%0d", n, op));
    end

    // 64-bit radix-4 instance
    do_op(1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
          64'h5555_5555_5555_5555, 34, "divu64");
`ifdef MULDIV_REM_FUSE_EN
    do_op(1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
          64'h0, 1, "remu64");
`else
    do_op(1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
          64'h0, 34, "remu64");
`endif
    do_op(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 3, "mulhu64");

    // reset asserted mid-divide
    @(negedge clk);
    v32 = 1'b1; op32 = 3'd5; a32 = 32'd999; b32 = 32'd5;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy32, 1);
    reset = 1'b0;
    #1;
    chk("midrst.busy", busy32, 0);
    chk("midrst.valid", ov32, 0);
    chk("midrst.res", res32, 0);
    chk("midrst.in_ready", r32, 1);
    @(negedge clk);
    reset = 1'b1;
    c_ok = 1'b0;
    run32(3'd4, 32'hFFFF_FF00, 32'd16, "post_rst_div");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
